// File: rtl/usb_sie_pkg.sv
// Shared USB serial-interface-engine definitions: PID codes, PID class decode,
// CRC polynomials/init/residual values and a bit-serial CRC5 helper.
package usb_sie_pkg;

    // 4-bit PID codes (the low nibble of the PID byte)
    typedef enum logic [3:0] {
        PidOut    = 4'b0001,
        PidIn     = 4'b1001,
        PidSof    = 4'b0101,
        PidSetup  = 4'b1101,
        PidData0  = 4'b0011,
        PidData1  = 4'b1011,
        PidData2  = 4'b0111,
        PidMdata  = 4'b1111,
        PidAck    = 4'b0010,
        PidNak    = 4'b1010,
        PidStall  = 4'b1110,
        PidNyet   = 4'b0110,
        PidPreErr = 4'b1100,
        PidSplit  = 4'b1000,
        PidPing   = 4'b0100
    } pid_e;

    typedef enum logic [1:0] {
        PidClsToken,
        PidClsData,
        PidClsHsk
    } pid_class_e;

    localparam logic [4:0]  Crc5Poly      = 5'h05;
    localparam logic [4:0]  Crc5Init      = 5'h1F;
    localparam logic [4:0]  Crc5Residual  = 5'b01100;
    localparam logic [15:0] Crc16Poly     = 16'h8005;
    localparam logic [15:0] Crc16Init     = 16'hFFFF;
    localparam logic [15:0] Crc16Residual = 16'h800D;

    // PID byte is valid when the check nibble is the complement and the PID is not reserved
    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return (pid_byte[7:4] == ~pid_byte[3:0]) && (pid_byte[3:0] != 4'b0000);
    endfunction

    // Special PIDs (PRE/ERR, SPLIT, PING) share the token packet format
    function automatic pid_class_e pid_class(input logic [3:0] pid);
        pid_class_e cls;
        case (pid[1:0])
            2'b11:   cls = PidClsData;
            2'b10:   cls = PidClsHsk;
            default: cls = PidClsToken;
        endcase
        return cls;
    endfunction

    // OUT/IN/SETUP/SOF are the tokens that report tok_valid
    function automatic logic pid_is_std_token(input logic [3:0] pid);
        return pid[1:0] == 2'b01;
    endfunction

    // Runs all 16 token bits (LSB first, byte0 then byte1) through CRC5; returns the residual
    function automatic logic [4:0] crc5(input logic [15:0] bits);
        logic [4:0] c;
        c = Crc5Init;
        for (int i = 0; i < 16; i++) begin
            if (c[4] ^ bits[i]) c = {c[3:0], 1'b0} ^ Crc5Poly;
            else                c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide USB CRC16 (LSB-first serial equivalent), usable by receive and transmit paths.
module usb_crc16
    import usb_sie_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_next;

    // Eight serial CRC steps, data bit 0 first
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[15] ^ data[i]) crc_next = {crc_next[14:0], 1'b0} ^ Crc16Poly;
            else                        crc_next = {crc_next[14:0], 1'b0};
        end
    end

    // CRC register: reset to zero, clear loads the init value, en absorbs one byte
    always_ff @(posedge clk) begin
        if (rst)        crc <= 16'h0000;
        else if (clear) crc <= Crc16Init;
        else if (en)    crc <= crc_next;
    end

endmodule

// File: rtl/usb_sie_rx.sv
// USB SIE receive path: PID check, token decode with CRC5, data payload streaming with
// CRC16 and a two-byte delay so CRC bytes never reach the payload output.
module usb_sie_rx
    import usb_sie_pkg::*;
#(
    parameter int unsigned MAX_DATA = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_active,
    input  logic        rx_valid,
    input  logic        rx_error,
    input  logic [7:0]  data_out,
    output logic [3:0]  pkt_pid,
    output logic        pkt_start,
    output logic        pkt_end,
    output logic        pkt_err,
    output logic        tok_valid,
    output logic [6:0]  tok_addr,
    output logic [3:0]  tok_endp,
    output logic [10:0] frame_num,
    output logic [7:0]  data_byte,
    output logic        data_valid,
    output logic [10:0] data_len
);

    typedef enum logic [2:0] {StIdle, StPid, StToken, StData, StHsk, StDrop} state_e;

    // Payload plus two CRC bytes is the most a data packet may carry
    localparam logic [11:0] MaxCnt = 12'(MAX_DATA + 2);

    state_e      state_q;
    logic [11:0] cnt_q;
    logic        err_q;
    logic        armed_q;
    logic [7:0]  d0_q;
    logic [7:0]  d1_q;

    logic        beat;
    logic        crc16_clear;
    logic        crc16_en;
    logic [15:0] crc16_val;
    logic        end_err;
    logic        tok_good;
    logic [10:0] len_calc;

    assign beat        = rx_active && rx_valid;
    assign crc16_clear = (state_q == StIdle);
    assign crc16_en    = (state_q == StData) && beat && !rx_error && (cnt_q != MaxCnt);

    usb_crc16 u_crc16 (
        .clk   (clk),
        .rst   (rst),
        .clear (crc16_clear),
        .en    (crc16_en),
        .data  (data_out),
        .crc   (crc16_val)
    );

    // End-of-packet status for whichever state the packet finishes in
    always_comb begin
        end_err  = 1'b1;
        tok_good = 1'b0;
        len_calc = (cnt_q >= 12'd2) ? 11'(cnt_q - 12'd2) : 11'd0;
        case (state_q)
            StToken: end_err = err_q || (cnt_q != 12'd2) || (crc5({d1_q, d0_q}) != Crc5Residual);
            StData:  end_err = err_q || (cnt_q < 12'd2) || (crc16_val != Crc16Residual);
            StHsk:   end_err = err_q;
            default: end_err = 1'b1;
        endcase
        tok_good = (state_q == StToken) && !end_err && pid_is_std_token(pkt_pid);
    end

    // Receive FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 12'd0;
            err_q      <= 1'b0;
            armed_q    <= 1'b0;
            d0_q       <= 8'h00;
            d1_q       <= 8'h00;
            pkt_pid    <= 4'h0;
            pkt_start  <= 1'b0;
            pkt_end    <= 1'b0;
            pkt_err    <= 1'b0;
            tok_valid  <= 1'b0;
            tok_addr   <= 7'h00;
            tok_endp   <= 4'h0;
            frame_num  <= 11'h000;
            data_byte  <= 8'h00;
            data_valid <= 1'b0;
            data_len   <= 11'h000;
        end else begin
            pkt_start  <= 1'b0;
            pkt_end    <= 1'b0;
            pkt_err    <= 1'b0;
            tok_valid  <= 1'b0;
            data_valid <= 1'b0;
            // A packet already in flight when reset lifts is ignored until the bus goes idle
            if (!rx_active) armed_q <= 1'b1;

            unique case (state_q)
                StIdle: begin
                    if (rx_active && armed_q) begin
                        state_q <= StPid;
                        cnt_q   <= 12'd0;
                        err_q   <= 1'b0;
                    end
                end
                default: begin
                    if (!rx_active) begin
                        state_q <= StIdle;
                        // A packet that never delivered a PID byte ends silently
                        if (state_q != StPid) begin
                            pkt_end   <= 1'b1;
                            pkt_err   <= end_err;
                            tok_valid <= tok_good;
                            data_len  <= len_calc;
                            if (tok_good) begin
                                if (pkt_pid == PidSof) begin
                                    frame_num <= {d1_q[2:0], d0_q};
                                end else begin
                                    tok_addr <= d0_q[6:0];
                                    tok_endp <= {d1_q[2:0], d0_q[7]};
                                end
                            end
                        end
                    end else if (rx_error) begin
                        state_q <= StDrop;
                        err_q   <= 1'b1;
                    end else if (beat) begin
                        case (state_q)
                            StPid: begin
                                if (pid_ok(data_out)) begin
                                    pkt_pid   <= data_out[3:0];
                                    pkt_start <= 1'b1;
                                    case (pid_class(data_out[3:0]))
                                        PidClsData: state_q <= StData;
                                        PidClsHsk:  state_q <= StHsk;
                                        default:    state_q <= StToken;
                                    endcase
                                end else begin
                                    state_q <= StDrop;
                                end
                            end
                            StToken: begin
                                if (cnt_q == 12'd2) begin
                                    err_q <= 1'b1;
                                end else begin
                                    d0_q  <= d1_q;
                                    d1_q  <= data_out;
                                    cnt_q <= cnt_q + 12'd1;
                                end
                            end
                            StData: begin
                                if (cnt_q == MaxCnt) begin
                                    err_q   <= 1'b1;
                                    state_q <= StDrop;
                                end else begin
                                    // Oldest held byte is now known not to be CRC
                                    if (cnt_q >= 12'd2) begin
                                        data_byte  <= d0_q;
                                        data_valid <= 1'b1;
                                    end
                                    d0_q  <= d1_q;
                                    d1_q  <= data_out;
                                    cnt_q <= cnt_q + 12'd1;
                                end
                            end
                            StHsk:   err_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_sie_rx.sv
// Directed bench for usb_sie_rx: tokens, data packets, handshakes, errors and reset.
module tb_usb_sie_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_active;
    logic        rx_valid;
    logic        rx_error;
    logic [7:0]  data_out;
    logic [3:0]  pkt_pid;
    logic        pkt_start;
    logic        pkt_end;
    logic        pkt_err;
    logic        tok_valid;
    logic [6:0]  tok_addr;
    logic [3:0]  tok_endp;
    logic [10:0] frame_num;
    logic [7:0]  data_byte;
    logic        data_valid;
    logic [10:0] data_len;

    always #5 clk = ~clk;

    usb_sie_rx #(.MAX_DATA(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_active  (rx_active),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .data_out   (data_out),
        .pkt_pid    (pkt_pid),
        .pkt_start  (pkt_start),
        .pkt_end    (pkt_end),
        .pkt_err    (pkt_err),
        .tok_valid  (tok_valid),
        .tok_addr   (tok_addr),
        .tok_endp   (tok_endp),
        .frame_num  (frame_num),
        .data_byte  (data_byte),
        .data_valid (data_valid),
        .data_len   (data_len)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cnt, end_cnt, dv_cnt, both_cnt;
    int          end_cyc, fall_cyc;
    logic        end_err, end_tok;
    logic [10:0] end_len;
    logic [7:0]  dbuf [32];
    logic [7:0]  pkt_q [$];
    logic [7:0]  exp_d [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge
    always @(negedge clk) begin
        if (pkt_start) start_cnt++;
        if (pkt_end) begin
            end_cnt++;
            end_cyc = cyc;
            end_err = pkt_err;
            end_tok = tok_valid;
            end_len = data_len;
        end
        if (tok_valid && pkt_err) both_cnt++;
        if (data_valid) begin
            if (dv_cnt < 32) dbuf[dv_cnt] = data_byte;
            dv_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_mon();
        start_cnt = 0;
        end_cnt   = 0;
        dv_cnt    = 0;
        end_err   = 1'bx;
        end_tok   = 1'bx;
        end_len   = 'x;
    endtask

    task automatic begin_pkt();
        clear_mon();
        @(posedge clk); #1 rx_active = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic send_bytes();
        foreach (pkt_q[i]) begin
            rx_valid = 1'b1;
            data_out = pkt_q[i];
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic finish_pkt();
        rx_valid  = 1'b0;
        rx_active = 1'b0;
        fall_cyc  = cyc;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt();
        begin_pkt();
        send_bytes();
        finish_pkt();
    endtask

    // Checks a packet that ended with one pkt_end exactly one cycle after rx_active fell
    task automatic check_end(input string tag, input int exp_start, input logic exp_err,
                             input logic exp_tok);
        check({tag, ".start"}, start_cnt, exp_start);
        check({tag, ".end"}, end_cnt, 1);
        check({tag, ".err"}, end_err, exp_err);
        check({tag, ".tok"}, end_tok, exp_tok);
        check({tag, ".lat"}, end_cyc, fall_cyc + 1);
    endtask

    initial begin
        rst = 1'b1; rx_active = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; data_out = 8'h00;
        both_cnt = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst.pid", pkt_pid, 4'h0);
        check("rst.addr", tok_addr, 7'h0);
        check("rst.frame", frame_num, 11'h0);
        check("rst.len", data_len, 11'h0);
        check("rst.pulses", {pkt_start, pkt_end, pkt_err, tok_valid, data_valid}, 5'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // SETUP addr 0 endp 0
        pkt_q = '{8'h2D, 8'h00, 8'h10}; send_pkt();
        check_end("setup", 1, 1'b0, 1'b1);
        check("setup.pid", pkt_pid, 4'hD);
        check("setup.fields", {tok_addr, tok_endp}, {7'h00, 4'h0});

        // OUT addr 0x15 endp 0xE
        pkt_q = '{8'hE1, 8'h15, 8'hEF}; send_pkt();
        check_end("out", 1, 1'b0, 1'b1);
        check("out.fields", {tok_addr, tok_endp}, {7'h15, 4'hE});

        // Corrupted SETUP leaves token fields alone
        pkt_q = '{8'h2D, 8'h00, 8'h11}; send_pkt();
        check_end("badcrc5", 1, 1'b1, 1'b0);
        check("badcrc5.fields", {tok_addr, tok_endp}, {7'h15, 4'hE});

        // Short token
        pkt_q = '{8'h2D, 8'h00}; send_pkt();
        check_end("shorttok", 1, 1'b1, 1'b0);
        check("shorttok.fields", {tok_addr, tok_endp}, {7'h15, 4'hE});

        // SOF with same 16 bits: frame 0x715, addr/endp untouched
        pkt_q = '{8'hA5, 8'h15, 8'hEF}; send_pkt();
        check_end("sof", 1, 1'b0, 1'b1);
        check("sof.frame", frame_num, 11'h715);

        // DATA0 with 8-byte payload (exactly MAX_DATA)
        pkt_q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
        send_pkt();
        check_end("data0", 1, 1'b0, 1'b0);
        check("data0.len", end_len, 11'd8);
        check("data0.dvcnt", dv_cnt, 8);
        exp_d = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        for (int i = 0; i < 8; i++) check($sformatf("data0.b%0d", i), dbuf[i], exp_d[i]);

        // Zero-length DATA1
        pkt_q = '{8'h4B, 8'h00, 8'h00}; send_pkt();
        check_end("zlp", 1, 1'b0, 1'b0);
        check("zlp.len", end_len, 11'd0);
        check("zlp.dvcnt", dv_cnt, 0);

        // DATA1 missing a CRC byte
        pkt_q = '{8'h4B, 8'h00}; send_pkt();
        check_end("shortdata", 1, 1'b1, 1'b0);

        // Overflow: 9-byte payload with MAX_DATA=8
        pkt_q = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                  8'h0A, 8'h0B};
        send_pkt();
        check_end("ovf", 1, 1'b1, 1'b0);
        check("ovf.dvcnt", dv_cnt, 8);
        check("ovf.last", dbuf[7], 8'h08);
        check("ovf.len", end_len, 11'd8);

        // ACK
        pkt_q = '{8'hD2}; send_pkt();
        check_end("ack", 1, 1'b0, 1'b0);
        check("ack.pid", pkt_pid, 4'h2);

        // ACK followed by a stray byte
        pkt_q = '{8'hD2, 8'h00}; send_pkt();
        check_end("ackextra", 1, 1'b1, 1'b0);

        // Bad PID check nibble
        pkt_q = '{8'hD3}; send_pkt();
        check_end("badpid", 0, 1'b1, 1'b0);

        // rx_active with no byte at all
        pkt_q = {}; send_pkt();
        check("nobyte.start", start_cnt, 0);
        check("nobyte.end", end_cnt, 0);

        // rx_error in the middle of a DATA0
        begin_pkt();
        pkt_q = '{8'hC3, 8'h80, 8'h06}; send_bytes();
        rx_error = 1'b1;
        @(posedge clk); #1 rx_error = 1'b0;
        pkt_q = '{8'h00, 8'h01}; send_bytes();
        finish_pkt();
        check_end("rxerr", 1, 1'b1, 1'b0);

        // Reset in the middle of a DATA0, bus stays active across reset
        begin_pkt();
        pkt_q = '{8'hC3, 8'h80, 8'h06, 8'h00}; send_bytes();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst.pid", pkt_pid, 4'h0);
        check("midrst.fields", {tok_addr, tok_endp}, {7'h00, 4'h0});
        check("midrst.frame", frame_num, 11'h0);
        check("midrst.pulses", {pkt_start, pkt_end, pkt_err, tok_valid, data_valid}, 5'b0);
        rst = 1'b0;
        clear_mon();
        pkt_q = '{8'h01, 8'h00, 8'h00, 8'h40}; send_bytes();
        finish_pkt();
        check("midrst.start", start_cnt, 0);
        check("midrst.end", end_cnt, 0);
        check("midrst.dv", dv_cnt, 0);

        // Receiver works normally once the bus has gone idle
        pkt_q = '{8'hD2}; send_pkt();
        check_end("postrst", 1, 1'b0, 1'b0);
        check("postrst.pid", pkt_pid, 4'h2);

        check("tok_and_err", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_sie_rx.md
USB_SIE_RX -- requirements
Module: usb_sie_rx

Interface
REQ-001 SHALL have parameter MAX_DATA, default 1023, maximum data payload in bytes before overflow error.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port rx_active  input  1  UTMI receive active.
REQ-005 SHALL have port rx_valid  input  1  UTMI data_out byte valid (qualified by rx_active).
REQ-006 SHALL have port rx_error  input  1  UTMI receive error.
REQ-007 SHALL have port data_out  input  8  UTMI received byte.
REQ-008 SHALL have port pkt_pid  output  4  PID of the current/last packet.
REQ-009 SHALL have port pkt_start  output  1  one-cycle pulse: valid PID accepted.
REQ-010 SHALL have port pkt_end  output  1  one-cycle pulse: packet finished, status outputs valid.
REQ-011 SHALL have port pkt_err  output  1  with pkt_end: PID, CRC, length or rx_error failure.
REQ-012 SHALL have port tok_valid  output  1  with pkt_end: good token (OUT/IN/SETUP/SOF).
REQ-013 SHALL have port tok_addr / tok_endp / frame_num  output  7/4/11  token fields; held until next token.
REQ-014 SHALL have port data_byte / data_valid  output  8/1  payload stream, CRC16 bytes excluded.
REQ-015 SHALL have port data_len  output  11  payload byte count, valid with pkt_end.

Function
REQ-016 SHALL use FSM states IDLE, PID, TOKEN, DATA, HSK, DROP.
REQ-017 IDLE->PID on rx_active high; a byte counts only when rx_active && rx_valid.
REQ-018 In PID, first byte SHALL be checked: data_out[7:4] == ~data_out[3:0] and PID != 0000; pass -> pkt_start next cycle, state by PID class; fail -> DROP.
REQ-019 TOKEN SHALL take exactly 2 bytes: byte0 = addr[6:0], endp[0] in bit7; byte1 = endp[3:1] in [2:0], CRC5 in [7:3]; SOF byte0/byte1[2:0] SHALL form frame_num.
REQ-020 CRC5 (poly x^5+x^2+1, init 5'h1F, LSB first) over all 16 token bits SHALL leave residual 5'b01100, else pkt_err.
REQ-021 DATA0/1/2/MDATA: CRC16 (poly 0x8005, init 16'hFFFF, LSB first) over all bytes incl. CRC SHALL leave residual 16'h800D, else pkt_err.
REQ-022 Payload SHALL be delayed 2 bytes: byte n emitted (data_valid one cycle) the cycle after byte n+2 is received; last 2 bytes never emitted.
REQ-023 Data packet with <2 bytes after PID, or >MAX_DATA+2, SHALL set pkt_err; overflow -> DROP, output stops.
REQ-024 HSK (ACK/NAK/STALL/NYET) SHALL have zero bytes after PID; any extra byte -> pkt_err. PRE/ERR/SPLIT/PING SHALL be treated as token-format.
REQ-025 Token with byte count != 2 SHALL set pkt_err and leave token fields unchanged.
REQ-026 rx_error high in any non-IDLE state SHALL move to DROP; pkt_err reported at end.
REQ-027 rx_active falling in any non-IDLE state SHALL produce pkt_end (with pkt_err/tok_valid/data_len) exactly one cycle later and return to IDLE.
REQ-028 rx_active low in PID state (no byte) SHALL return to IDLE with no pkt_start/pkt_end.
REQ-029 tok_valid SHALL never assert together with pkt_err.

Reset
REQ-030 rst SHALL force IDLE and all outputs to 0, including token fields, data_len and CRC registers, overriding any packet in progress.
REQ-031 After rst deassertion while rx_active is already high, the block SHALL wait in DROP-equivalent until rx_active low, with no pkt_end.

Structure
REQ-032 PID enum, PID-class decode, CRC polynomials, init values and residuals SHALL live in shared package usb_sie_pkg, with a CRC5 function.
REQ-033 Byte-wide CRC16 update SHALL be sub-module usb_crc16 (clk, rst, clear, en, data, crc), reusable by a future transmitter.

Verification
REQ-034 SETUP 2D 00 10 -> pkt_start, pkt_end, tok_valid=1, tok_addr=0, tok_endp=0, pkt_err=0.
REQ-035 Corrupt token 2D 00 11 -> pkt_end with pkt_err=1, tok_valid=0, token fields unchanged.
REQ-036 DATA0 C3 80 06 00 01 00 00 40 00 DD 94 -> 8 data_valid pulses 80 06 00 01 00 00 40 00, data_len=8, pkt_err=0.
REQ-037 Zero-length DATA1 4B 00 00 -> no data_valid, data_len=0, pkt_err=0; DATA1 4B 00 -> pkt_err=1.
REQ-038 ACK D2 -> pkt_pid=2, pkt_err=0; bad PID D3 -> no pkt_start, pkt_end with pkt_err=1.
REQ-039 rx_error pulse mid-DATA0, then rx_active low -> DROP, pkt_end with pkt_err=1; rst mid-packet -> all outputs 0, no pkt_end.
